// File: rtl/fetch_pkg.sv
// Shared fetch-queue types: FSM encoding, queue entry layout, constants.
// Used by fetch_fifo and fetch_queue (optional FETCH_PERF_EN counters).
package fetch_pkg;

  localparam int FQ_ENTRY_W = 64;
  localparam logic [31:0] FQ_NOP = 32'h0000_0013;

  typedef enum logic {
    FQ_FETCH   = 1'b0,
    FQ_DISCARD = 1'b1
  } fqState_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcNext;
  } fqEntry_t;

  function automatic bit depthOk(int d);
    return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of {inst, pc+4} entries with push/pop/flush.
// Head holds the last shown entry once the buffer drains.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fqEntry_t               wrData,
  output fqEntry_t               head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fqEntry_t       mem [DEPTH];
  fqEntry_t       hold;
  logic [AW-1:0]  rdPtr;
  logic [AW-1:0]  wrPtr;

  if ($bits(fqEntry_t) != FQ_ENTRY_W) begin : gBadEntry
    $error("fetch_fifo: entry width mismatch");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      hold  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {FQ_NOP, 32'h0};
      end
    end else begin
      if (count != '0) hold <= mem[rdPtr];
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
        count <= '0;
      end else begin
        if (push) begin
          mem[wrPtr] <= wrData;
          wrPtr      <= wrPtr + 1'b1;
        end
        if (pop) rdPtr <= rdPtr + 1'b1;
        count <= count + (AW+1)'(push)
                       - (AW+1)'(pop);
      end
    end
  end

  assign head = (count != '0) ? mem[rdPtr] : hold;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, imem req/ack handshake, prefetch queue to IF/ID.
// Define FETCH_PERF_EN to add perf_fetched / perf_flushed counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall,
  output logic                   if_valid,
  output logic [31:0]            if_inst,
  output logic [31:0]            if_pc_next,
  output logic [$clog2(DEPTH):0] fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            perf_fetched,
  output logic [31:0]            perf_flushed
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  if (!depthOk(DEPTH)) begin : gBadDepth
    $error("fetch_queue: DEPTH must be 2..16, pow2");
  end

  fqState_t      state;
  fqState_t      stateNext;
  logic [31:0]   fetchPc;
  logic [31:0]   fetchPcNext;
  logic [31:0]   addrQ;
  logic          reqQ;
  logic          ackNow;
  logic          pushNow;
  logic          popNow;
  logic [CW-1:0] countNext;
  fqEntry_t      head;
  fqEntry_t      wrData;

  always_comb begin
    ackNow    = reqQ & imem_ack;
    pushNow   = ackNow && (state == FQ_FETCH)
                && !redirect;
    popNow    = if_valid && !stall && !redirect;
    countNext = redirect ? '0
              : fq_count + CW'(pushNow)
                         - CW'(popNow);
    fetchPcNext = fetchPc;
    if (redirect)
      fetchPcNext = redirect_pc & ~32'd3;
    else if (pushNow)
      fetchPcNext = fetchPc + 32'd4;
    stateNext = state;
    if (ackNow)
      stateNext = FQ_FETCH;
    else if (redirect && reqQ)
      stateNext = FQ_DISCARD;
  end

  // A request, once raised, is frozen until its ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FQ_FETCH;
      fetchPc <= RESET_PC;
      reqQ    <= 1'b0;
      addrQ   <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      if (!(reqQ && !imem_ack)) begin
        reqQ  <= (stateNext == FQ_FETCH)
                 && (countNext < CW'(DEPTH));
        addrQ <= fetchPcNext;
      end
    end
  end

  assign wrData = '{inst:   imem_rdata,
                    pcNext: addrQ + 32'd4};

  fetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk    (clk),
    .rst    (rst),
    .push   (pushNow),
    .pop    (popNow),
    .flush  (redirect),
    .wrData (wrData),
    .head   (head),
    .count  (fq_count)
  );

  assign imem_req   = reqQ;
  assign imem_addr  = addrQ;
  assign if_valid   = (fq_count != '0);
  assign if_inst    = head.inst;
  assign if_pc_next = head.pcNext;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pushNow)
        perf_fetched <= perf_fetched + 32'd1;
      if (redirect)
        perf_flushed <= perf_flushed
          + 32'(fq_count)
          + 32'(reqQ && (state == FQ_FETCH));
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based model.
// Build with FETCH_PERF_EN to also check the perf counters.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          stall;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc_next;
  logic [CW-1:0] fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_flushed;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] q[$];
  logic [31:0] mPc, mAddr;
  logic [31:0] mHoldInst, mHoldPc;
  bit          mReq, mDiscard;
  int          mFetched, mFlushed;
  int          waitCnt, lat;
  bit          randLat;
  int          stallPct, redirPct;

  fetch_queue #(.DEPTH(DEPTH),
                .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc_next  (if_pc_next),
    .fq_count    (fq_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(
    input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic idle();
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall       = 1'b0;
  endtask

  task automatic ackNow(input bit a);
    imem_ack   = a;
    imem_rdata = a ? word(imem_addr) : $urandom;
  endtask

  // Reference: what the queue must hold after this edge.
  task automatic modelUpdate();
    bit acked;
    if (rst) begin
      q.delete();
      mPc = 0; mAddr = 0;
      mReq = 0; mDiscard = 0;
      mHoldInst = 0; mHoldPc = 0;
      mFetched = 0; mFlushed = 0;
      waitCnt = 0;
      return;
    end
    acked = mReq && imem_ack;
    if (redirect) begin
      mFlushed += q.size()
                + ((mReq && !mDiscard) ? 1 : 0);
      q.delete();
      mPc = redirect_pc & ~32'd3;
    end else begin
      if (q.size() > 0 && !stall)
        void'(q.pop_front());
      if (acked && !mDiscard) begin
        q.push_back({word(mAddr),
                     mAddr + 32'd4});
        mPc = mAddr + 32'd4;
        mFetched++;
      end
    end
    if (acked) mDiscard = 0;
    else if (redirect && mReq) mDiscard = 1;
    if (acked) begin
      waitCnt = 0;
      if (randLat) lat = $urandom_range(0, 3);
    end else if (mReq) begin
      waitCnt++;
    end
    if (!(mReq && !imem_ack)) begin
      mReq  = q.size() < DEPTH;
      mAddr = mPc;
    end
  endtask

  task automatic step();
    logic [31:0] eInst, ePc;
    modelUpdate();
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mHoldInst = q[0][63:32];
      mHoldPc   = q[0][31:0];
    end
    eInst = mHoldInst;
    ePc   = mHoldPc;
    checks++;
    if (if_valid !== (q.size() > 0)) begin
      errors++;
      $display("FAIL if_valid: got %b want %b",
               if_valid, q.size() > 0);
    end
    checks++;
    if (fq_count !== CW'(q.size())) begin
      errors++;
      $display("FAIL fq_count: got %0d want %0d",
               fq_count, q.size());
    end
    checks++;
    if (if_inst !== eInst) begin
      errors++;
      $display("FAIL if_inst: got %h want %h",
               if_inst, eInst);
    end
    checks++;
    if (if_pc_next !== ePc) begin
      errors++;
      $display("FAIL if_pc_next: got %h want %h",
               if_pc_next, ePc);
    end
    checks++;
    if (imem_req !== mReq) begin
      errors++;
      $display("FAIL imem_req: got %b want %b",
               imem_req, mReq);
    end
    if (mReq) begin
      checks++;
      if (imem_addr !== mAddr) begin
        errors++;
        $display("FAIL imem_addr: got %h want %h",
                 imem_addr, mAddr);
      end
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 32'(mFetched)) begin
      errors++;
      $display("FAIL perf_fetched: got %0d want %0d",
               perf_fetched, mFetched);
    end
    checks++;
    if (perf_flushed !== 32'(mFlushed)) begin
      errors++;
      $display("FAIL perf_flushed: got %0d want %0d",
               perf_flushed, mFlushed);
    end
`endif
  endtask

  task automatic driveAuto();
    ackNow(imem_req && (waitCnt >= lat));
    stall    = $urandom_range(0, 99) < stallPct;
    redirect = $urandom_range(0, 99) < redirPct;
    if ($urandom_range(0, 1) == 0)
      redirect_pc = $urandom;
    else
      redirect_pc = 32'hFFFF_FFF0
                  | $urandom_range(0, 15);
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({imem_req, if_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00",
               {imem_req, if_valid});
    end
    checks++;
    if ({if_inst, if_pc_next} !== 64'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
               {if_inst, if_pc_next});
    end
    checks++;
    if (fq_count !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0",
               fq_count);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if ({perf_fetched, perf_flushed} !== 64'h0) begin
      errors++;
      $display("FAIL reset_perf: got %h want 0",
               {perf_fetched, perf_flushed});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_stream();
    randLat = 0; lat = 0;
    stallPct = 0; redirPct = 0;
    driveAuto(); step();
    driveAuto(); step();
    checks++;
    if (if_pc_next !== 32'd4 || !if_valid) begin
      errors++;
      $display("FAIL stream_first: got %h want 4",
               if_pc_next);
    end
    driveAuto(); step();
    checks++;
    if (if_pc_next !== 32'd8) begin
      errors++;
      $display("FAIL stream_second: got %h want 8",
               if_pc_next);
    end
    for (int i = 0; i < 10; i++) begin
      driveAuto(); step();
    end
  endtask

  task automatic test_stall();
    stallPct = 100;
    for (int i = 0; i < 10; i++) begin
      driveAuto(); step();
    end
    checks++;
    if (fq_count !== CW'(DEPTH) || imem_req) begin
      errors++;
      $display("FAIL stall_full: got %0d/%b want %0d/0",
               fq_count, imem_req, DEPTH);
    end
    stallPct = 0;
    for (int i = 0; i < 10; i++) begin
      driveAuto(); step();
    end
  endtask

  task automatic test_discard();
    bit sawAck;
    doReset();
    randLat = 0; lat = 3;
    stallPct = 0; redirPct = 0;
    driveAuto(); step();
    driveAuto();
    redirect = 1'b1;
    redirect_pc = 32'h100;
    step();
    checks++;
    if (!imem_req || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL discard_hold: got %b/%h want 1/0",
               imem_req, imem_addr);
    end
    sawAck = 0;
    for (int i = 0; i < 10 && !sawAck; i++) begin
      driveAuto();
      sawAck = imem_ack;
      step();
    end
    checks++;
    if (!sawAck || !imem_req
        || imem_addr !== 32'h100 || if_valid) begin
      errors++;
      $display("FAIL discard_refetch: got %b/%h/%b want 1/100/0",
               imem_req, imem_addr, if_valid);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 0 || perf_flushed !== 1) begin
      errors++;
      $display("FAIL discard_perf: got %0d/%0d want 0/1",
               perf_fetched, perf_flushed);
    end
`endif
    for (int i = 0; i < 8; i++) begin
      driveAuto(); step();
    end
  endtask

  task automatic test_redirect_ack();
    doReset();
    stall = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      ackNow(1'b1); step();
    end
    ackNow(1'b1);
    stall = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h40;
    step();
    checks++;
    if (fq_count !== '0 || if_valid) begin
      errors++;
      $display("FAIL redir_ack_flush: got %0d/%b want 0/0",
               fq_count, if_valid);
    end
    checks++;
    if (!imem_req || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_ack_addr: got %b/%h want 1/40",
               imem_req, imem_addr);
    end
    idle();
  endtask

  task automatic test_align_wrap();
    doReset();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    checks++;
    if (imem_addr !== 32'h200) begin
      errors++;
      $display("FAIL align: got %h want 200",
               imem_addr);
    end
    redirect_pc = 32'hFFFF_FFFC;
    ackNow(1'b1);
    step();
    redirect = 1'b0;
    stall = 1'b1;
    ackNow(1'b1);
    step();
    checks++;
    if (!if_valid || if_pc_next !== 32'h0
        || if_inst !== word(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap: got %b/%h want 1/0",
               if_valid, if_pc_next);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: got %h want 0",
               imem_addr);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    doReset();
    stall = 1'b1;
    step();
    ackNow(1'b1); step();
    ackNow(1'b1); step();
    ackNow(1'b0); step();
    rst = 1'b1;
    step();
    checks++;
    if ({imem_req, if_valid, fq_count} !== '0
        || {if_inst, if_pc_next} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid: got %b/%b/%0d/%h want 0",
               imem_req, if_valid, fq_count, if_inst);
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_random();
    doReset();
    randLat = 1; lat = 1;
    stallPct = 30; redirPct = 4;
    for (int i = 0; i < 3000; i++) begin
      driveAuto(); step();
    end
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst = 1'b1;
    randLat = 0; lat = 0;
    stallPct = 0; redirPct = 0;
    waitCnt = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_discard();
    test_redirect_ack();
    test_align_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
